reg_file_param: RTL and testbench

Parametrised register file for the datapath: NR general-purpose registers (R1..Rn) and NT temporary registers (T1..Tn), each NBITS wide, with a shared 2-bit function select (decrement, increment, load, clear), per-register write enables and two independently selected registered read ports. It replaces the fixed 4+4 x 8-bit file, adds reset, same-cycle enables, sticky per-register wrap flags, a zero flag on port 1 and optional write-to-read bypass. It sits between the ALU result bus and the ALU operand inputs.

---
 rtl/reg_file_param_if.sv | 28 ++
 rtl/reg_file_param.sv | 114 +++++++++++
 tb/tb_reg_file_param.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: function/enable/load inputs, read selects and read-port outputs.
interface reg_file_param_if #(
    parameter int NBITS = 8,
    parameter int NR    = 4,
    parameter int NT    = 4,
    localparam int SELW = $clog2(NR + NT)
);
    logic [1:0]       funsel;
    logic [NR-1:0]    rsel;
    logic [NT-1:0]    tsel;
    logic [NBITS-1:0] din;
    logic [SELW-1:0]  o1sel;
    logic [SELW-1:0]  o2sel;
    logic [NBITS-1:0] o1;
    logic [NBITS-1:0] o2;
    logic             o1_zero;
    logic [NT+NR-1:0] wrap;

    modport master (
        output funsel, rsel, tsel, din, o1sel, o2sel,
        input  o1, o2, o1_zero, wrap
    );

    modport slave (
        input  funsel, rsel, tsel, din, o1sel, o2sel,
        output o1, o2, o1_zero, wrap
    );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: NR general + NT temporary registers with shared dec/inc/load/clear, sticky wrap
// flags and two registered read ports. Define RF_BYPASS_EN for write-to-read forwarding.
module reg_file_param #(
    parameter int NBITS = 8,
    parameter int NR    = 4,
    parameter int NT    = 4,
    localparam int SELW = $clog2(NR + NT)
) (
    input logic             clk,
    input logic             rst_n,
    reg_file_param_if.slave bus
);
    localparam int NREG = NT + NR;
    localparam logic [NBITS-1:0] ONE = NBITS'(1);

    typedef enum logic [1:0] {
        FN_DEC  = 2'b00,
        FN_INC  = 2'b01,
        FN_LOAD = 2'b10,
        FN_CLR  = 2'b11
    } fun_e;

    fun_e             fn;
    logic [NREG-1:0]  en;
    logic [NREG-1:0]  wrap_q;
    logic [NBITS-1:0] src [NREG];
    logic [SELW-1:0]  s1, s2;
    logic [NBITS-1:0] rd1, rd2;
    logic [NBITS-1:0] o1_q, o2_q;
    logic             o1_zero_q;

    assign fn = fun_e'(bus.funsel);
    assign s1 = bus.o1sel;
    assign s2 = bus.o2sel;

    // Storage follows the read-select encoding (T1..Tn, then R1..Rn); enables are MSB-first.
    for (genvar i = 0; i < NT; i++) begin : g_ten
        assign en[i] = bus.tsel[NT-1-i];
    end
    for (genvar j = 0; j < NR; j++) begin : g_ren
        assign en[NT+j] = bus.rsel[NR-1-j];
    end

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        logic [NBITS-1:0] q, d;
        logic             w_q, w_d;

        always_comb begin
            d   = q;
            w_d = w_q;
            if (en[i]) begin
                case (fn)
                    FN_DEC: begin
                        d = q - ONE;
                        if (q == '0) w_d = 1'b1;
                    end
                    FN_INC: begin
                        d = q + ONE;
                        if (q == '1) w_d = 1'b1;
                    end
                    FN_LOAD: begin
                        d   = bus.din;
                        w_d = 1'b0;
                    end
                    FN_CLR: begin
                        d   = '0;
                        w_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q   <= '0;
                w_q <= 1'b0;
            end else begin
                q   <= d;
                w_q <= w_d;
            end
        end

        assign wrap_q[i] = w_q;
`ifdef RF_BYPASS_EN
        assign src[i] = d;
`else
        assign src[i] = q;
`endif
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (32'(s1) < NREG) rd1 = src[s1];
        if (32'(s2) < NREG) rd2 = src[s2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o1_q      <= '0;
            o2_q      <= '0;
            o1_zero_q <= 1'b1;
        end else begin
            o1_q      <= rd1;
            o2_q      <= rd2;
            o1_zero_q <= (rd1 == '0);
        end
    end

    assign bus.o1      = o1_q;
    assign bus.o2      = o2_q;
    assign bus.o1_zero = o1_zero_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: array-based reference model, directed cases plus random traffic.
module tb_reg_file_param;
    localparam int NBITS = 8;
    localparam int NR    = 4;
    localparam int NT    = 3;
    localparam int NREG  = NR + NT;
    localparam int SELW  = $clog2(NREG);
    localparam longint unsigned MOD = 64'd1 << NBITS;

    typedef longint unsigned arr_t [NREG];
    typedef struct {
        logic [NBITS-1:0] o1;
        logic [NBITS-1:0] o2;
        logic             z;
        logic [NREG-1:0]  wrap;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_param_if #(.NBITS(NBITS), .NR(NR), .NT(NT)) bus ();
    reg_file_param #(.NBITS(NBITS), .NR(NR), .NT(NT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t            sbq[$];
    int              checks = 0;
    int              errors = 0;
    arr_t            mdl;
    logic [NREG-1:0] mwrap;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] rbit(input int k);
        return NR'(1) << (NR - k);
    endfunction

    function automatic logic [NT-1:0] tbit(input int k);
        return NT'(1) << (NT - k);
    endfunction

    function automatic longint unsigned rd(input int sel, input arr_t a);
        if (sel >= NREG) return 0;
        return a[sel];
    endfunction

    // Drive one cycle of stimulus at a falling edge, push what the next rising edge must produce.
    task automatic op(input logic [1:0] fs, input logic [NR-1:0] r, input logic [NT-1:0] t,
                      input logic [NBITS-1:0] d, input int s1, input int s2);
        arr_t            nv;
        logic [NREG-1:0] nw;
        exp_t            e;
        bit              en;
        bus.funsel = fs;
        bus.rsel   = r;
        bus.tsel   = t;
        bus.din    = d;
        bus.o1sel  = SELW'(s1);
        bus.o2sel  = SELW'(s2);
        nv = mdl;
        nw = mwrap;
        for (int i = 0; i < NREG; i++) begin
            if (i < NT) en = t[NT-1-i];
            else        en = r[NR-1-(i-NT)];
            if (en) begin
                case (fs)
                    2'b00: begin
                        nv[i] = (mdl[i] + MOD - 1) % MOD;
                        if (mdl[i] == 0) nw[i] = 1'b1;
                    end
                    2'b01: begin
                        nv[i] = (mdl[i] + 1) % MOD;
                        if (mdl[i] == MOD - 1) nw[i] = 1'b1;
                    end
                    2'b10: begin
                        nv[i] = longint'(d);
                        nw[i] = 1'b0;
                    end
                    default: begin
                        nv[i] = 0;
                        nw[i] = 1'b0;
                    end
                endcase
            end
        end
`ifdef RF_BYPASS_EN
        e.o1 = NBITS'(rd(s1, nv));
        e.o2 = NBITS'(rd(s2, nv));
`else
        e.o1 = NBITS'(rd(s1, mdl));
        e.o2 = NBITS'(rd(s2, mdl));
`endif
        e.z    = (e.o1 == '0);
        e.wrap = nw;
        sbq.push_back(e);
        mdl   = nv;
        mwrap = nw;
        @(negedge clk);
    endtask

    task automatic rdop(input int s1, input int s2);
        op(2'b01, '0, '0, '0, s1, s2);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                check("o1", bus.o1, e.o1);
                check("o2", bus.o2, e.o2);
                check("o1_zero", bus.o1_zero, e.z);
                check("wrap", bus.wrap, e.wrap);
            end
        end
    end

    initial begin
        bus.funsel = 2'b11;
        bus.rsel   = '0;
        bus.tsel   = '0;
        bus.din    = '0;
        bus.o1sel  = '0;
        bus.o2sel  = '0;
        mdl   = '{default: 0};
        mwrap = '0;
        repeat (3) @(negedge clk);
        check("rst_o1", bus.o1, 0);
        check("rst_o2", bus.o2, 0);
        check("rst_o1_zero", bus.o1_zero, 1);
        check("rst_wrap", bus.wrap, 0);
        rst_n = 1'b1;

        // load R1 and read it back through both ports
        op(2'b10, rbit(1), '0, 8'hA5, NT, NT);
        rdop(NT, NT);
        rdop(NT, 0);
        // wrap up on T1, then a load clears the flag
        op(2'b10, '0, tbit(1), 8'hFF, 0, 0);
        op(2'b01, '0, tbit(1), 8'h00, 0, 0);
        op(2'b10, '0, tbit(1), 8'h10, 0, 0);
        rdop(0, 0);
        // wrap down on R4, then clear
        op(2'b11, rbit(4), '0, 8'h77, NT + 3, NT + 3);
        op(2'b00, rbit(4), '0, 8'h77, NT + 3, NT + 3);
        rdop(NT + 3, NT + 3);
        op(2'b11, rbit(4), '0, 8'h77, NT + 3, NT + 3);
        rdop(NT + 3, NT + 3);
        // simultaneous increment of R1 and R2, only R2 wraps
        op(2'b10, rbit(1), '0, 8'h01, NT, NT + 1);
        op(2'b10, rbit(2), '0, 8'hFF, NT, NT + 1);
        op(2'b01, rbit(1) | rbit(2), '0, 8'h00, NT + 1, NT + 1);
        rdop(NT + 1, NT + 1);
        rdop(NT, NT + 1);
        // out-of-range selects
        rdop(NREG, (1 << SELW) - 1);
        rdop((1 << SELW) - 1, NT);

        repeat (400) begin
            op(2'($urandom_range(0, 3)),
               NR'($urandom & $urandom),
               NT'($urandom & $urandom),
               NBITS'($urandom),
               $urandom_range(0, (1 << SELW) - 1),
               $urandom_range(0, (1 << SELW) - 1));
        end

        // asynchronous reset in the middle of a cycle with a load pending
        op(2'b10, rbit(1), '0, 8'h5A, NT, NT);
        op(2'b10, rbit(1), '0, 8'h5A, NT, NT);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_o1", bus.o1, 0);
        check("midrst_o2", bus.o2, 0);
        check("midrst_o1_zero", bus.o1_zero, 1);
        check("midrst_wrap", bus.wrap, 0);
        sbq.delete();
        mdl   = '{default: 0};
        mwrap = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < NREG; s++) rdop(s, NREG - 1 - s);
        rdop(NT, NT);

        for (int n = 0; n < 10 && sbq.size() > 0; n++) @(posedge clk);
        #2;
        check("drain", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
